framebuffer_writer: RTL and testbench

//  Downstream stage of the rasterizer. Deserializes the three bit-serial pixel words (x, y, colour)
//  and converts the Q10.6 coordinates to integer pixel indices. Clips to the screen and buffers

---
 rtl/framebuffer_writer_if.sv | 12 +
 rtl/framebuffer_writer.sv | 210 +++++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_writer_if.sv
// Framebuffer memory write port: address/data held with the request until the memory acknowledges.
interface framebuffer_writer_if #(
  parameter int AW = 17
) ();
  logic [AW-1:0] addr;
  logic [15:0]   wdata;
  logic          we;
  logic          ack;

  modport master (output addr, output wdata, output we, input ack);
  modport slave  (input addr, input wdata, input we, output ack);
endinterface

// File: rtl/framebuffer_writer.sv
// Rasterizer back end: deserializes bit-serial Q10.6 pixels, clips them, queues them in a small FIFO
// and writes them to framebuffer memory; also performs full-screen clears and signals triangle completion.
module framebuffer_writer #(
  parameter int FRAC       = 6,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 px_i,
  input  logic                 py_i,
  input  logic                 c_i,
  input  logic                 valid_i,
  input  logic                 done_i,
  input  logic                 clear_i,
  input  logic [15:0]          bg_color_i,
  framebuffer_writer_if.master mem,
  output logic                 busy_o,
  output logic                 tri_drawn_o,
  output logic                 overflow_o,
  output logic [15:0]          clip_cnt_o
);

  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] WIDTH_A   = AW'(WIDTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);
  localparam logic signed [15:0] WIDTH_S  = 16'(WIDTH);
  localparam logic signed [15:0] HEIGHT_S = 16'(HEIGHT);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   color;
  } pixel_t;

  // ---------------------------------------------------------------------------
  // Serial capture
  // ---------------------------------------------------------------------------
  logic        cap_active_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] x_sr_q, y_sr_q, c_sr_q;
  logic        conv_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_active_q <= 1'b0;
      bit_cnt_q    <= '0;
      x_sr_q       <= '0;
      y_sr_q       <= '0;
      c_sr_q       <= '0;
      conv_q       <= 1'b0;
    end else begin
      conv_q <= 1'b0;
      if (cap_active_q) begin
        x_sr_q    <= {x_sr_q[14:0], px_i};
        y_sr_q    <= {y_sr_q[14:0], py_i};
        c_sr_q    <= {c_sr_q[14:0], c_i};
        bit_cnt_q <= bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          cap_active_q <= 1'b0;
          conv_q       <= 1'b1;
        end
      end else if (valid_i) begin
        cap_active_q <= 1'b1;
        bit_cnt_q    <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Coordinate conversion and clipping
  // ---------------------------------------------------------------------------
  logic signed [15:0] xs, ys;
  logic               in_screen;
  logic [AW-1:0]      pix_addr;

  assign xs        = $signed(x_sr_q) >>> FRAC;
  assign ys        = $signed(y_sr_q) >>> FRAC;
  assign in_screen = !xs[15] && (xs < WIDTH_S) && !ys[15] && (ys < HEIGHT_S);
  assign pix_addr  = AW'($unsigned(ys)) * WIDTH_A + AW'($unsigned(xs));

  // ---------------------------------------------------------------------------
  // Pixel FIFO
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  pixel_t        fifo_q [FIFO_DEPTH];
  pixel_t        head;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          empty, full, push_req, push, pop, drop;
  logic          mem_we_w;
  logic          overflow_q;
  logic [15:0]   clip_cnt_q;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign head     = fifo_q[rd_ptr_q];
  assign pop      = (state_q == S_IDLE) && !empty && mem.ack;
  assign push_req = conv_q && in_screen;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // NOTE: the storage array has no reset; occupancy is tracked by count_q, and the head is gated off the bus when empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: pix_addr, color: c_sr_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW + 1)'(push) - (PW + 1)'(pop);
      if (drop) overflow_q <= 1'b1;
      if (conv_q && !in_screen && clip_cnt_q != 16'hFFFF) clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write port / clear FSM
  // ---------------------------------------------------------------------------
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [15:0]   bg_q, bg_d;
  logic [AW-1:0] mem_addr_w;
  logic [15:0]   mem_wdata_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      bg_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      bg_q       <= bg_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    bg_d        = bg_q;
    mem_we_w    = 1'b0;
    mem_addr_w  = '0;
    mem_wdata_w = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          mem_we_w    = 1'b1;
          mem_addr_w  = head.addr;
          mem_wdata_w = head.color;
        end else if (clear_i) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
          bg_d       = bg_color_i;
        end
      end
      S_CLEAR: begin
        mem_we_w    = 1'b1;
        mem_addr_w  = clr_addr_q;
        mem_wdata_w = bg_q;
        if (mem.ack) begin
          if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
          else                         clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem.we    = mem_we_w;
  assign mem.addr  = mem_addr_w;
  assign mem.wdata = mem_wdata_w;

  // ---------------------------------------------------------------------------
  // Triangle completion
  // ---------------------------------------------------------------------------
  logic pending_q;
  logic drained;

  assign drained = pending_q && !cap_active_q && !conv_q && empty && !mem_we_w && (state_q == S_IDLE);

  // A fresh DONE wins over the clearing pulse so a new triangle is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pending_q <= 1'b0;
    else if (done_i)  pending_q <= 1'b1;
    else if (drained) pending_q <= 1'b0;
  end

  assign tri_drawn_o = drained;
  assign overflow_o  = overflow_q;
  assign clip_cnt_o  = clip_cnt_q;
  assign busy_o      = cap_active_q | conv_q | !empty | mem_we_w | (state_q != S_IDLE) | pending_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed self-checking bench for framebuffer_writer: capture, clipping, FIFO overflow, clear and reset abort.
module tb_framebuffer_writer;
  localparam int AW      = 17;
  localparam int NPIX    = 320 * 240;

  logic        clk = 1'b0;
  logic        rst;
  logic        px, py, c, valid, done, clear;
  logic [15:0] bg_color;
  logic        busy, tri_drawn, overflow;
  logic [15:0] clip_cnt;

  framebuffer_writer_if #(.AW(AW)) mem_if ();

  framebuffer_writer #(
    .FRAC(6), .WIDTH(320), .HEIGHT(240), .FIFO_DEPTH(4), .AW(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .px_i       (px),
    .py_i       (py),
    .c_i        (c),
    .valid_i    (valid),
    .done_i     (done),
    .clear_i    (clear),
    .bg_color_i (bg_color),
    .mem        (mem_if.master),
    .busy_o     (busy),
    .tri_drawn_o(tri_drawn),
    .overflow_o (overflow),
    .clip_cnt_o (clip_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] log_addr[$];
  logic [15:0]   log_data[$];

  // Records every accepted write; values at the falling edge are those the next rising edge sees.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_if.we === 1'b1 && mem_if.ack === 1'b1) begin
      log_addr.push_back(mem_if.addr);
      log_data.push_back(mem_if.wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pixel(input logic [15:0] x, input logic [15:0] y, input logic [15:0] col);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      px = x[i];
      py = y[i];
      c  = col[i];
      tick();
    end
    px = 1'b0;
    py = 1'b0;
    c  = 1'b0;
  endtask

  initial begin : stim
    int tri_at;
    int bad;
    int n_before;

    rst = 1'b1; px = 0; py = 0; c = 0; valid = 0; done = 0; clear = 0;
    bg_color = 16'h0000; mem_if.ack = 1'b0;
    tick(2);
    check("rst_we", 32'(mem_if.we), 32'd0);
    check("rst_addr", 32'(mem_if.addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clip", 32'(clip_cnt), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single pixel, exact write timing, then triangle completion
    mem_if.ack = 1'b1;
    send_pixel(16'h0140, 16'h0080, 16'hF800);
    check("t1_we_before", 32'(mem_if.we), 32'd0);
    tick();
    check("t1_we", 32'(mem_if.we), 32'd1);
    check("t1_addr", 32'(mem_if.addr), 32'd645);
    check("t1_wdata", 32'(mem_if.wdata), 32'hF800);
    tick();
    check("t1_we_after", 32'(mem_if.we), 32'd0);
    check("t1_nwrites", 32'(log_addr.size()), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t1_tri", 32'(tri_drawn), 32'd1);
    tick();
    check("t1_tri_end", 32'(tri_drawn), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: floor conversion and clipping
    send_pixel(16'h017F, 16'h00BF, 16'h1234);
    tick(2);
    check("t2_nwrites", 32'(log_addr.size()), 32'd2);
    check("t2_floor_addr", 32'(log_addr[1]), 32'd645);
    check("t2_floor_data", 32'(log_data[1]), 32'h1234);
    send_pixel(16'hFFC0, 16'h0080, 16'h5555);
    tick(2);
    check("t2_clip_negx", 32'(clip_cnt), 32'd1);
    send_pixel(16'h5000, 16'h0080, 16'h5555);
    tick(2);
    check("t2_clip_x320", 32'(clip_cnt), 32'd2);
    send_pixel(16'h0000, 16'h3C00, 16'h5555);
    tick(2);
    check("t2_clip_y240", 32'(clip_cnt), 32'd3);
    check("t2_no_write", 32'(log_addr.size()), 32'd2);

    // 3: FIFO overflow with ACK held low, then in-order drain
    mem_if.ack = 1'b0;
    log_addr.delete();
    log_data.delete();
    for (int i = 0; i < 4; i++) send_pixel(16'(i * 64), 16'h0040, 16'(16'h1000 + i));
    check("t3_ovf_clear", 32'(overflow), 32'd0);
    for (int i = 4; i < 6; i++) send_pixel(16'(i * 64), 16'h0040, 16'(16'h1000 + i));
    tick();
    check("t3_ovf_set", 32'(overflow), 32'd1);
    check("t3_hold_addr", 32'(mem_if.addr), 32'd320);
    check("t3_hold_data", 32'(mem_if.wdata), 32'h1000);
    check("t3_no_write", 32'(log_addr.size()), 32'd0);
    mem_if.ack = 1'b1;
    tick(5);
    check("t3_nwrites", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_order_addr", 32'(log_addr[i]), 32'(320 + i));
      check("t3_order_data", 32'(log_data[i]), 32'(16'h1000 + i));
    end
    check("t3_busy", 32'(busy), 32'd0);

    // 4+5: clear held off by a buffered pixel, mid-clear pixel and DONE
    mem_if.ack = 1'b0;
    log_addr.delete();
    log_data.delete();
    send_pixel(16'h0280, 16'h0280, 16'h07E0);
    tick();
    bg_color = 16'h001F;
    clear = 1'b1;
    tick(3);
    check("t5_held_we", 32'(mem_if.we), 32'd1);
    check("t5_held_addr", 32'(mem_if.addr), 32'd3210);
    mem_if.ack = 1'b1;
    tick(4);
    clear = 1'b0;
    send_pixel(16'h0040, 16'h0000, 16'hABCD);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t5_no_tri_mid", 32'(tri_drawn), 32'd0);
    tri_at = -1;
    for (int i = 0; i < 80000 && tri_at < 0; i++) begin
      if (tri_drawn === 1'b1) tri_at = log_addr.size();
      else tick();
    end
    check("t5_tri_after", 32'(tri_at), 32'(NPIX + 2));
    check("t4_nwrites", 32'(log_addr.size()), 32'(NPIX + 2));
    if (log_addr.size() == NPIX + 2) begin
      check("t5_first_addr", 32'(log_addr[0]), 32'd3210);
      check("t5_first_data", 32'(log_data[0]), 32'h07E0);
      bad = 0;
      for (int i = 1; i <= NPIX; i++)
        if (log_addr[i] !== AW'(i - 1) || log_data[i] !== 16'h001F) bad++;
      check("t4_clear_seq", 32'(bad), 32'd0);
      check("t4_tail_addr", 32'(log_addr[NPIX + 1]), 32'd1);
      check("t4_tail_data", 32'(log_data[NPIX + 1]), 32'hABCD);
    end
    tick();
    check("t5_busy", 32'(busy), 32'd0);

    // 6: reset aborts a clear in progress
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    for (int i = 0; i < 2000 && !(mem_if.we === 1'b1 && mem_if.addr == AW'(1000)); i++) tick();
    check("t6_reached_1000", 32'(mem_if.addr), 32'd1000);
    rst = 1'b1;
    #1;
    check("t6_we", 32'(mem_if.we), 32'd0);
    check("t6_addr", 32'(mem_if.addr), 32'd0);
    check("t6_wdata", 32'(mem_if.wdata), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_clip", 32'(clip_cnt), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_tri", 32'(tri_drawn), 32'd0);
    n_before = log_addr.size();
    tick(2);
    rst = 1'b0;
    tick(10);
    check("t6_no_resume", 32'(log_addr.size()), 32'(n_before));
    check("t6_we_idle", 32'(mem_if.we), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
